mux_nin_pipe: RTL and testbench
===============================

MUX_NIN_PIPE -- requirements
Module: mux_nin_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 16: bit width of each data input and of the output.
REQ-003 Parameter N_IN, default 4, legal range 2..16: number of data inputs.
REQ-004 Parameter SEL_W, default 2: select width, equal to ceil(log2(N_IN)).
REQ-005 Port clk, input, 1: rising-edge clock for all state.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port in_data, input, N_IN*WIDTH: packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port sel, input, SEL_W: input index, sampled on acceptance.
REQ-009 Port in_valid, input, 1: upstream offers in_data/sel this cycle.
REQ-010 Port in_ready, output, 1: block accepts this cycle.
REQ-011 Port out_data, output, WIDTH: registered selected data.
REQ-012 Port out_valid, output, 1: out_data holds an unconsumed word.
REQ-013 Port out_ready, input, 1: downstream consumes this cycle.
REQ-014 Port sel_err, output, 1: registered flag, the held word was accepted with sel >= N_IN.
REQ-015 Port xfer_cnt, output, 16: count of words accepted since reset.

Function
REQ-016 The block SHALL be a one-entry registered mux with a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 in_ready SHALL be combinational: 1 when the FSM is EMPTY, or when it is FULL and out_ready=1.
REQ-018 A word SHALL be accepted on any rising edge where in_valid=1 and in_ready=1.
REQ-019 On acceptance, out_data SHALL load in_data[sel*WIDTH +: WIDTH] and the FSM SHALL go to FULL, giving a latency of one cycle.
REQ-020 The transition EMPTY->FULL SHALL occur on acceptance, and FULL->EMPTY SHALL occur on out_ready=1 without acceptance.
REQ-021 In FULL, simultaneous out_ready=1 and acceptance SHALL replace the word and keep FULL, with no bubble (full throughput).
REQ-022 In FULL with out_ready=0, out_data, sel_err and out_valid SHALL hold, and in_ready SHALL be 0.
REQ-023 in_data and sel SHALL be ignored whenever no acceptance occurs.
REQ-024 xfer_cnt SHALL increment by 1 per acceptance and wrap from 0xFFFF to 0x0000.
REQ-025 out_data SHALL retain its last value after the FSM returns to EMPTY.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL set the FSM to EMPTY, out_valid=0, out_data=0, sel_err=0 and xfer_cnt=0.
REQ-027 Reset SHALL take priority over any concurrent handshake, and a word held at reset SHALL be discarded.
REQ-028 During rst=1, in_ready SHALL be driven 0.

Configuration
REQ-029 Macro MUX_SEL_CHECK_EN SHALL control out-of-range select handling.
REQ-030 With MUX_SEL_CHECK_EN defined, an acceptance with sel >= N_IN SHALL load out_data=0 and sel_err=1, and an in-range acceptance SHALL load sel_err=0.
REQ-031 Without MUX_SEL_CHECK_EN, sel >= N_IN SHALL select input 0, sel_err SHALL be constant 0, and no comparison logic SHALL be present.

Verification
REQ-032 Scenario: N_IN=4, WIDTH=16, inputs 0x1111/0x2222/0x3333/0x4444, sel=2, in_valid=1 for one cycle from EMPTY, out_ready=0 -> the next cycle gives out_valid=1 and out_data=0x3333, after which in_ready=0 and the values hold.
REQ-033 Scenario: in_valid=1 and out_ready=1 continuously for 8 cycles, with sel cycling 0,1,2,3 -> out_data follows 0x1111,0x2222,0x3333,0x4444 repeating one cycle late, with no bubble, and xfer_cnt=8.
REQ-034 Scenario: FULL holding 0x4444, out_ready=1 with in_valid=0 -> the next cycle gives out_valid=0 and out_data still 0x4444.
REQ-035 Scenario: N_IN=3, sel=3 accepted -> with MUX_SEL_CHECK_EN: out_data=0x0000 and sel_err=1; without it: out_data=0x1111 and sel_err=0.
REQ-036 Scenario: assert rst for one cycle while FULL with out_ready=0 -> the next cycle gives out_valid=0, out_data=0, xfer_cnt=0 and sel_err=0.
REQ-037 Scenario: force xfer_cnt to 0xFFFF, then one acceptance -> xfer_cnt=0x0000.

Source files
------------

// File: rtl/mux_nin_pipe_if.sv
// Handshake bus for mux_nin_pipe: N_IN packed inputs with select in, one registered word out.
interface mux_nin_pipe_if #(
  parameter int WIDTH = 16,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
);
  logic [N_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]      sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;
  logic [15:0]           xfer_cnt;

  modport master (
    output in_data, sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err, xfer_cnt
  );

  modport slave (
    input  in_data, sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err, xfer_cnt
  );
endinterface

// File: rtl/mux_nin_pipe.sv
// One-entry registered N-input mux with valid/ready handshake and acceptance counter.
// Define MUX_SEL_CHECK_EN to zero the output and flag sel_err on out-of-range selects.

module mux_nin_pipe_lane #(
  parameter int WIDTH = 16
) (
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] dout
);
  assign dout = en ? data : '0;
endmodule

module mux_nin_pipe #(
  parameter int WIDTH = 16,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input logic           clk,
  input logic           rst,
  mux_nin_pipe_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]                  state_q;
  logic [WIDTH-1:0]            data_q;
  logic [15:0]                 cnt_q;
  logic [N_IN-1:1]             dec;
  logic [N_IN-1:0]             en;
  logic [N_IN-1:0][WIDTH-1:0]  lane_d;
  logic [WIDTH-1:0]            mux_d;
  logic                        acc;

  // One-hot decode of every legal non-zero select value
  for (genvar k = 1; k < N_IN; k++) begin : g_dec
    assign dec[k] = (bus.sel == SEL_W'(k));
  end

`ifdef MUX_SEL_CHECK_EN
  logic err_q;
  // No lane enabled means the select was out of range: output falls to zero
  assign en[N_IN-1:1] = dec;
  assign en[0]        = (bus.sel == '0);
  assign bus.sel_err  = err_q;
`else
  // Lane 0 catches both sel==0 and every unmatched select
  assign en[N_IN-1:1] = dec;
  assign en[0]        = ~|dec;
  assign bus.sel_err  = 1'b0;
`endif

  for (genvar k = 0; k < N_IN; k++) begin : g_lane
    mux_nin_pipe_lane #(.WIDTH(WIDTH)) u_lane (
      .en   (en[k]),
      .data (bus.in_data[k*WIDTH +: WIDTH]),
      .dout (lane_d[k])
    );
  end

  always_comb begin
    mux_d = '0;
    for (int k = 0; k < N_IN; k++) mux_d |= lane_d[k];
  end

  assign bus.in_ready  = !rst && (state_q == EMPTY || bus.out_ready);
  assign acc           = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.xfer_cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else if (acc) begin
      state_q <= FULL;
      data_q  <= mux_d;
      cnt_q   <= cnt_q + 16'd1;
    end else if (bus.out_ready) begin
      state_q <= EMPTY;
    end
  end

`ifdef MUX_SEL_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)      err_q <= 1'b0;
    else if (acc) err_q <= ~|en;
  end
`endif
endmodule

// File: tb/tb_mux_nin_pipe.sv
// Directed bench for mux_nin_pipe: a 4-input instance for handshake/counter behaviour
// and a 3-input instance for out-of-range select handling.
module tb_mux_nin_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_nin_pipe_if #(.WIDTH(16), .N_IN(4), .SEL_W(2)) b4 ();
  mux_nin_pipe_if #(.WIDTH(16), .N_IN(3), .SEL_W(2)) b3 ();

  mux_nin_pipe #(.WIDTH(16), .N_IN(4), .SEL_W(2)) u4 (.clk(clk), .rst(rst), .bus(b4));
  mux_nin_pipe #(.WIDTH(16), .N_IN(3), .SEL_W(2)) u3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_d;
    rst          = 1'b1;
    b4.in_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    b4.sel       = '0;
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b0;
    b3.in_data   = {16'h3333, 16'h2222, 16'h1111};
    b3.sel       = '0;
    b3.in_valid  = 1'b0;
    b3.out_ready = 1'b0;

    tick();
    b4.in_valid = 1'b1;
    #1 chk("rst_in_ready", b4.in_ready, 0);
    b4.in_valid = 1'b0;
    tick();
    chk("rst_out_valid", b4.out_valid, 0);
    chk("rst_out_data",  b4.out_data,  0);
    chk("rst_cnt",       b4.xfer_cnt,  0);
    chk("rst_sel_err",   b4.sel_err,   0);
    rst = 1'b0;

    // single accept, downstream stalled
    b4.sel = 2'd2; b4.in_valid = 1'b1;
    #1 chk("empty_in_ready", b4.in_ready, 1);
    tick();
    b4.in_valid = 1'b0;
    chk("lat1_valid", b4.out_valid, 1);
    chk("lat1_data",  b4.out_data,  16'h3333);
    chk("lat1_cnt",   b4.xfer_cnt,  1);
    #1 chk("full_stall_ready", b4.in_ready, 0);
    b4.sel = 2'd0; b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0;
    chk("hold_data",  b4.out_data,  16'h3333);
    chk("hold_valid", b4.out_valid, 1);
    chk("hold_cnt",   b4.xfer_cnt,  1);

    // back-to-back streaming
    b4.out_ready = 1'b1; b4.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b4.sel = 2'(i % 4);
      exp_d  = 16'h1111 * 16'(i % 4 + 1);
      tick();
      chk($sformatf("stream_data%0d", i), b4.out_data, exp_d);
      chk($sformatf("stream_valid%0d", i), b4.out_valid, 1);
    end
    chk("stream_cnt", b4.xfer_cnt, 9);

    // drain, data retained
    b4.in_valid = 1'b0;
    tick();
    chk("drain_valid", b4.out_valid, 0);
    chk("drain_data",  b4.out_data,  16'h4444);
    chk("drain_ready", b4.in_ready,  1);

    // new input pattern, then reset while full
    b4.in_data = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h0F0F};
    b4.out_ready = 1'b0; b4.sel = 2'd1; b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0;
    chk("pat2_data", b4.out_data, 16'hCAFE);
    rst = 1'b1;
    #1 chk("rst_hi_ready", b4.in_ready, 0);
    tick();
    rst = 1'b0;
    chk("rstfull_valid", b4.out_valid, 0);
    chk("rstfull_data",  b4.out_data,  0);
    chk("rstfull_cnt",   b4.xfer_cnt,  0);
    chk("rstfull_err",   b4.sel_err,   0);

    // out-of-range select on 3-input instance
    b3.out_ready = 1'b1; b3.in_valid = 1'b1; b3.sel = 2'd3;
    tick();
`ifdef MUX_SEL_CHECK_EN
    chk("oor_data", b3.out_data, 16'h0000);
    chk("oor_err",  b3.sel_err,  1);
`else
    chk("oor_data", b3.out_data, 16'h1111);
    chk("oor_err",  b3.sel_err,  0);
`endif
    b3.sel = 2'd2;
    tick();
    b3.in_valid = 1'b0;
    chk("inr_data", b3.out_data, 16'h3333);
    chk("inr_err",  b3.sel_err,  0);
    chk("n3_cnt",   b3.xfer_cnt, 2);

    // counter wrap
    b4.out_ready = 1'b1; b4.in_valid = 1'b1; b4.sel = 2'd3;
    repeat (65535) tick();
    chk("cnt_max",  b4.xfer_cnt, 16'hFFFF);
    chk("max_data", b4.out_data, 16'hDEAD);
    tick();
    chk("cnt_wrap", b4.xfer_cnt, 16'h0000);
    b4.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
